riscv_multicycle: RTL and testbench
===================================

# riscv_multicycle

Parametrised multi-cycle RV32I core that follows the single-cycle core. It replaces that core's fixed single-cycle fetch/execute with an explicit state machine and valid/ack memory handshakes on separate instruction and data ports, so it tolerates wait-state memories. It adds the complete branch, JALR, and byte/halfword load/store set, an RV32E register option, a retire pulse, and a halt on SYSTEM or faulting instructions.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value loaded at reset.
- NREGS, 32, register count; 32 (RV32I) or 16 (RV32E). Registers with index ≥ NREGS read as 0 and writes to them are discarded.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address, equals pc.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  fetch completion.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_be  out  4  byte enables, lane i = bits [8i+7:8i].
- dmem_addr  out  32  word-aligned address, {ea[31:2],2'b00}.
- dmem_wdata  out  32  store data, replicated across lanes.
- dmem_rdata  in  32  load data; valid when dmem_ack=1.
- dmem_ack  in  1  data access completion.
- halt  out  1  sticky; core stopped.
- retired  out  1  one-cycle pulse per completed instruction.

## Operation
- States: FETCH, EXEC, MEM, HALT. Reset values: state=FETCH, pc=RESET_ADDR, halt=0, retired=0, dmem_req=0. The register file is not cleared; x0 is always 0.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - A transfer completes on the rising edge where imem_req=1 and imem_ack=1. The ack may arrive in the same cycle as the request.
  - On completion, latch imem_rdata into the instruction register and go to EXEC.
  - While reset_n=0, any ack is ignored.
- EXEC: decode and run the ALU (full RV32I ALU: ADD/SUB, shifts, SLT/SLTU, logic ops).
  - ALU, LUI, AUIPC, JAL, JALR: write rd, update pc, pulse retired, go to FETCH.
  - JAL/JALR: link value is pc+4. JALR target is (rs1+Iimm) with bit 0 cleared.
  - Branches BEQ, BNE, BLT, BGE, BLTU, BGEU: taken → pc+Bimm, not taken → pc+4.
  - A target with bit 1 set → HALT; pc and registers unchanged.
  - Load/store: ea=rs1+imm. A misaligned halfword (ea[0]=1) or word (ea[1:0]≠0) → HALT with no dmem_req. Otherwise go to MEM.
  - SYSTEM opcode or an unknown opcode → HALT.
- MEM:
  - dmem_req=1; addr, we, be, and wdata are held stable until the ack.
  - Byte enables: SB 4'b0001<<ea[1:0]; SH 4'b0011<<ea[1:0]; SW 4'b1111. Loads drive be with the same pattern.
  - On ack, loads select the addressed lane and extend it: LB/LH sign-extend, LBU/LHU zero-extend. The result is written to rd.
  - On ack: pc+=4, pulse retired, go to FETCH.
- HALT: halt=1; no requests issued. Only reset_n=0 exits this state.
- Writes to rd=0 are discarded. Register reads are combinational from the instruction register.
- Reset mid-transaction: the outstanding request is abandoned. The next cycle starts FETCH at RESET_ADDR, and a late ack is ignored.

## Timing
- With zero-wait memories (ack in the same cycle as req):
  - non-memory instruction: 2 cycles, FETCH+EXEC;
  - load/store: 3 cycles, FETCH+EXEC+MEM.
- Each wait cycle on imem_ack or dmem_ack adds exactly one cycle.
- retired is high in the cycle after the retiring edge, for exactly one cycle.
- Register write and pc update occur on the same edge as the transition to FETCH.
- halt rises in the cycle after the faulting EXEC edge.
- imem_req and dmem_req are never high in the same cycle.
- First fetch: imem_req=1 in the first cycle with reset_n=1, at imem_addr=RESET_ADDR.

## Test plan
- Arithmetic sequence, zero-wait: ADDI x1,x0,5; ADDI x2,x1,-3; ADD x3,x1,x2; SUB x4,x2,x1 → x3=7, x4=0xFFFFFFFD, 4 retired pulses spaced 2 cycles apart.
- Byte stores and loads: x5=0x100, x6=0x80; SB x6,3(x5) → dmem_be=4'b1000, dmem_addr=0x100, wdata=0x80808080. LB from 0x103 → 0xFFFFFF80; LBU → 0x00000080; SH/LH at 0x102 → be=4'b1100.
- Control flow: BEQ taken (x1==x1) jumps by +8; BNE not taken → pc+4. JAL x1,+16 at 0x20 → x1=0x24, pc=0x30. JALR x0,1(x7) with x7=0x40 → pc=0x40.
- Wait states: imem_ack delayed 3 cycles and dmem_ack delayed 2 on an LW → req and addresses stable throughout; total 1+3+1+1+2=8 cycles.
- Faults: LW from 0x102 → halt=1, dmem_req never asserted, no retired pulse. ECALL → halt=1, no further imem_req until reset.
- Reset and RV32E: reset_n=0 during MEM wait → next cycle dmem_req=0, pc=RESET_ADDR=0x1000. With NREGS=16, ADDI x20,x0,9 then ADD x1,x20,x0 → x1=0.

Source files
------------

// File: rtl/riscv_multicycle.sv
// riscv_multicycle: RV32I/RV32E core with valid/ack instruction and data ports.
//
// state | meaning
// FETCH | imem_req high at pc; on imem_ack latch the instruction
// EXEC  | decode and ALU; write back and retire, start a memory access, or halt
// MEM   | dmem_req high with address/data held; on dmem_ack finish and retire
// HALT  | SYSTEM, unknown or faulting instruction; only reset leaves
module riscv_multicycle #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          NREGS      = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        halt,
    output logic        retired
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [5:0] NREGS_L    = 6'(NREGS);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        retired_q, retired_d;
    logic [31:0] rf_q [32];
    logic        rf_we;
    logic [31:0] rf_wdata;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign rd_idx  = ir_q[11:7];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];

    // Registers above NREGS (RV32E) are not storage and read as zero, like x0.
    assign rs1_val = (rs1_idx != 5'd0 && {1'b0, rs1_idx} < NREGS_L) ? rf_q[rs1_idx] : 32'h0;
    assign rs2_val = (rs2_idx != 5'd0 && {1'b0, rs2_idx} < NREGS_L) ? rf_q[rs2_idx] : 32'h0;

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'h000};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    logic [31:0] alu_b, alu_y;
    logic        alu_alt;
    logic [4:0]  shamt;

    // SUB only exists for register-register ops; SRA/SRAI use bit 30 in both forms.
    assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign alu_alt = ir_q[30] && ((opcode == OPC_OP) || (funct3 == 3'b101));
    assign shamt   = alu_b[4:0];

    // ALU
    always_comb begin
        alu_y = 32'h0;
        case (funct3)
            3'b000:  alu_y = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
            3'b001:  alu_y = rs1_val << shamt;
            3'b010:  alu_y = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_y = {31'h0, rs1_val < alu_b};
            3'b100:  alu_y = rs1_val ^ alu_b;
            3'b101:  alu_y = alu_alt ? 32'($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
            3'b110:  alu_y = rs1_val | alu_b;
            default: alu_y = rs1_val & alu_b;
        endcase
    end

    logic br_take, br_ok;

    // Branch condition; funct3 010/011 are not branches
    always_comb begin
        br_take = 1'b0;
        br_ok   = 1'b1;
        case (funct3)
            3'b000:  br_take = (rs1_val == rs2_val);
            3'b001:  br_take = (rs1_val != rs2_val);
            3'b100:  br_take = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_take = !($signed(rs1_val) < $signed(rs2_val));
            3'b110:  br_take = (rs1_val < rs2_val);
            3'b111:  br_take = !(rs1_val < rs2_val);
            default: br_ok   = 1'b0;
        endcase
    end

    logic        is_store, mem_f3_ok, mem_misal;
    logic [31:0] ea, lane, load_y;
    logic [31:0] pc_plus4, br_tgt, jal_tgt, jalr_sum, jalr_tgt;

    assign is_store  = (opcode == OPC_STORE);
    assign ea        = rs1_val + (is_store ? imm_s : imm_i);
    assign mem_f3_ok = is_store ? (!funct3[2] && funct3[1:0] != 2'b11)
                                : (funct3[1:0] != 2'b11 && !(funct3[2] && funct3[1]));
    assign mem_misal = (funct3[1:0] == 2'b01 && ea[0]) ||
                       (funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
    assign lane      = dmem_rdata >> {ea[1:0], 3'b000};

    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_q + imm_b;
    assign jal_tgt  = pc_q + imm_j;
    assign jalr_sum = rs1_val + imm_i;
    assign jalr_tgt = {jalr_sum[31:1], 1'b0};

    // Load lane extraction and extension
    always_comb begin
        load_y = lane;
        case (funct3)
            3'b000:  load_y = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_y = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_y = {24'h0, lane[7:0]};
            3'b101:  load_y = {16'h0, lane[15:0]};
            default: load_y = lane;
        endcase
    end

    // Data port; everything derives from ir_q and registers, so it is stable in MEM
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = rs2_val;
        case (funct3[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << ea[1:0];
                dmem_wdata = {4{rs2_val[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << ea[1:0];
                dmem_wdata = {2{rs2_val[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = rs2_val;
            end
        endcase
    end

    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = is_store;
    assign dmem_addr = {ea[31:2], 2'b00};
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign halt      = (state_q == S_HALT);
    assign retired   = retired_q;

    // Next state, pc, instruction register and register write-back
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = alu_y;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d   = S_FETCH;
                pc_d      = pc_plus4;
                retired_d = 1'b1;
                case (opcode)
                    OPC_OP, OPC_OPIMM: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_y;
                    end
                    OPC_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_u;
                    end
                    OPC_AUIPC: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + imm_u;
                    end
                    OPC_JAL, OPC_JALR: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_plus4;
                        pc_d     = (opcode == OPC_JAL) ? jal_tgt : jalr_tgt;
                    end
                    OPC_BRANCH: begin
                        if (!br_ok) begin
                            retired_d = 1'b0;
                        end else if (br_take) begin
                            pc_d = br_tgt;
                        end
                    end
                    OPC_LOAD, OPC_STORE: begin
                        retired_d = 1'b0;
                        pc_d      = pc_q;
                        if (mem_f3_ok && !mem_misal) begin
                            state_d = S_MEM;
                        end else begin
                            state_d = S_HALT;
                        end
                    end
                    default: begin
                        retired_d = 1'b0;
                    end
                endcase
                // Unknown/SYSTEM ops and misaligned jump targets halt with no side effects.
                if ((retired_d == 1'b0 && state_d == S_FETCH) || pc_d[1]) begin
                    state_d   = S_HALT;
                    pc_d      = pc_q;
                    rf_we     = 1'b0;
                    retired_d = 1'b0;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    rf_we     = !is_store;
                    rf_wdata  = load_y;
                    pc_d      = pc_plus4;
                    retired_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Control state register; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_ADDR;
            ir_q      <= 32'h0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Register file write port; x0 and indices beyond NREGS are not storage
    always_ff @(posedge clk) begin
        if (reset_n && rf_we && rd_idx != 5'd0 && {1'b0, rd_idx} < NREGS_L) begin
            rf_q[rd_idx] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed bench for riscv_multicycle: a wait-state capable RV32I instance and an
// RV32E instance with a non-zero reset address.
module tb_riscv_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halt, retired;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    logic        reset_n_e, imem_req_e, imem_ack_e, dmem_req_e, dmem_we_e, dmem_ack_e;
    logic        halt_e, retired_e, dack_en;
    logic [31:0] imem_addr_e, imem_rdata_e, dmem_addr_e, dmem_wdata_e, dmem_rdata_e;
    logic [3:0]  dmem_be_e;

    riscv_multicycle #(.RESET_ADDR(32'h0000_0000), .NREGS(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .halt(halt), .retired(retired)
    );

    riscv_multicycle #(.RESET_ADDR(32'h0000_1000), .NREGS(16)) dut_e (
        .clk(clk), .reset_n(reset_n_e),
        .imem_req(imem_req_e), .imem_addr(imem_addr_e), .imem_rdata(imem_rdata_e), .imem_ack(imem_ack_e),
        .dmem_req(dmem_req_e), .dmem_we(dmem_we_e), .dmem_be(dmem_be_e), .dmem_addr(dmem_addr_e),
        .dmem_wdata(dmem_wdata_e), .dmem_rdata(dmem_rdata_e), .dmem_ack(dmem_ack_e),
        .halt(halt_e), .retired(retired_e)
    );

    // Memory model for the main core: programmable wait states per port
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    int          ilat, dlat, icnt, dcnt;

    assign imem_ack   = imem_req && (icnt >= ilat);
    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_ack   = dmem_req && (dcnt >= dlat);
    assign dmem_rdata = dmem[dmem_addr[9:2]];

    always @(posedge clk) begin
        if (!reset_n) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
            if (dmem_req && dmem_ack && dmem_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (dmem_be[i]) dmem[dmem_addr[9:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Memory model for the RV32E core: zero-wait fetch, data ack under bench control
    logic [31:0] imem_e [256];
    assign imem_ack_e   = imem_req_e;
    assign imem_rdata_e = imem_e[imem_addr_e[9:2]];
    assign dmem_ack_e   = dmem_req_e && dack_en;
    assign dmem_rdata_e = 32'h1234_5678;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                          input int rd, input int op);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                          input int op);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im;
        im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im;
        im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] im;
        im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction

    localparam logic [31:0] ECALL = 32'h0000_0073;

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        logic [31:0] a;
        a = addr;
        imem[a[9:2]] = w;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int          ret_cyc[$];
    logic [31:0] ifetch[$];
    logic [31:0] acc_addr[$];
    logic [31:0] acc_wd[$];
    logic [3:0]  acc_be[$];
    logic        acc_we[$];
    int          n_ireq, n_dreq, halt_cyc, unstable;

    // Observe the main core for ncyc cycles starting in the current cycle
    task automatic run(input int ncyc);
        logic        pi, pd, pwe;
        logic [31:0] pia, pa, pw;
        logic [3:0]  pb;
        ret_cyc.delete(); ifetch.delete(); acc_addr.delete(); acc_wd.delete();
        acc_be.delete(); acc_we.delete();
        n_ireq = 0; n_dreq = 0; halt_cyc = -1; unstable = 0;
        pi = 1'b0; pd = 1'b0; pwe = 1'b0; pia = 0; pa = 0; pw = 0; pb = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (retired) ret_cyc.push_back(c);
            if (imem_req && dmem_req) unstable++;
            if (imem_req) begin
                n_ireq++;
                if (pi && imem_addr !== pia) unstable++;
            end
            if (dmem_req) begin
                n_dreq++;
                if (pd && (dmem_addr !== pa || dmem_be !== pb || dmem_wdata !== pw || dmem_we !== pwe))
                    unstable++;
            end
            if (imem_req && imem_ack) ifetch.push_back(imem_addr);
            if (dmem_req && dmem_ack) begin
                acc_addr.push_back(dmem_addr);
                acc_wd.push_back(dmem_wdata);
                acc_be.push_back(dmem_be);
                acc_we.push_back(dmem_we);
            end
            if (halt && halt_cyc < 0) halt_cyc = c;
            pi = imem_req && !imem_ack;
            pd = dmem_req && !dmem_ack;
            pia = imem_addr; pa = dmem_addr; pw = dmem_wdata; pb = dmem_be; pwe = dmem_we;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int ret_at(input int i);
        return (i < ret_cyc.size()) ? ret_cyc[i] : -1;
    endfunction

    initial begin
        logic [31:0] exp_fetch[10];
        int          rcount_e;

        reset_n   = 1'b0;
        reset_n_e = 1'b0;
        dack_en   = 1'b0;
        ilat      = 0;
        dlat      = 0;
        for (int i = 0; i < 256; i++) begin
            dmem[i]   <= 32'h0;
            imem_e[i]  = 32'h0;
        end

        // Arithmetic sequence then ECALL
        clear_imem();
        put(32'h00, enc_i(5, 0, 0, 1, 7'h13));
        put(32'h04, enc_i(-3, 1, 0, 2, 7'h13));
        put(32'h08, enc_r(7'h00, 2, 1, 0, 3, 7'h33));
        put(32'h0C, enc_r(7'h20, 1, 2, 0, 4, 7'h33));
        put(32'h10, ECALL);
        do_reset();
        chk("rst_imem_req", 32'(imem_req), 1);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        run(14);
        chk("arith_retire_count", ret_cyc.size(), 4);
        for (int i = 0; i < 4; i++) chk("arith_retire_cycle", ret_at(i), 2 + 2 * i);
        chk("ecall_halt_cycle", halt_cyc, 10);
        chk("arith_fetch_cycles", n_ireq, 5);
        chk("arith_x1", dut.rf_q[1], 32'd5);
        chk("arith_x2", dut.rf_q[2], 32'd2);
        chk("arith_x3", dut.rf_q[3], 32'd7);
        chk("arith_x4", dut.rf_q[4], 32'hFFFF_FFFD);
        run(10);
        chk("halt_no_fetch", n_ireq, 0);
        chk("halt_sticky", 32'(halt), 1);
        chk("halt_no_retire", ret_cyc.size(), 0);

        // Byte and halfword stores and loads
        clear_imem();
        put(32'h00, enc_i(32'h100, 0, 0, 5, 7'h13));
        put(32'h04, enc_i(32'h80, 0, 0, 6, 7'h13));
        put(32'h08, enc_s(3, 6, 5, 0));
        put(32'h0C, enc_i(3, 5, 0, 7, 7'h03));
        put(32'h10, enc_i(3, 5, 4, 8, 7'h03));
        put(32'h14, enc_i(-2, 0, 0, 9, 7'h13));
        put(32'h18, enc_s(2, 9, 5, 1));
        put(32'h1C, enc_i(2, 5, 1, 10, 7'h03));
        put(32'h20, enc_i(2, 5, 5, 11, 7'h03));
        put(32'h24, ECALL);
        do_reset();
        run(30);
        chk("mem_retire_count", ret_cyc.size(), 9);
        chk("sb_retire_cycle", ret_at(2), 7);
        chk("mem_halt_cycle", halt_cyc, 26);
        chk("mem_access_count", acc_addr.size(), 6);
        if (acc_addr.size() == 6) begin
            chk("sb_we", 32'(acc_we[0]), 1);
            chk("sb_be", 32'(acc_be[0]), 32'h8);
            chk("sb_addr", acc_addr[0], 32'h100);
            chk("sb_wdata", acc_wd[0], 32'h8080_8080);
            chk("lb_we", 32'(acc_we[1]), 0);
            chk("lb_be", 32'(acc_be[1]), 32'h8);
            chk("sh_be", 32'(acc_be[3]), 32'hC);
            chk("sh_addr", acc_addr[3], 32'h100);
            chk("sh_wdata", acc_wd[3], 32'hFFFE_FFFE);
            chk("lh_be", 32'(acc_be[4]), 32'hC);
        end
        chk("lb_x7", dut.rf_q[7], 32'hFFFF_FF80);
        chk("lbu_x8", dut.rf_q[8], 32'h0000_0080);
        chk("lh_x10", dut.rf_q[10], 32'hFFFF_FFFE);
        chk("lhu_x11", dut.rf_q[11], 32'h0000_FFFE);
        chk("dmem_word", dmem[32'h40], 32'hFFFE_0000);

        // Control flow
        clear_imem();
        put(32'h00, enc_i(1, 0, 0, 13, 7'h13));
        put(32'h04, enc_b(8, 13, 13, 0));
        put(32'h08, enc_i(32'h77, 0, 0, 13, 7'h13));
        put(32'h0C, enc_b(8, 13, 13, 1));
        put(32'h10, enc_i(2, 0, 0, 14, 7'h13));
        put(32'h14, enc_i(32'h40, 0, 0, 7, 7'h13));
        put(32'h18, enc_b(8, 7, 13, 6));
        put(32'h1C, enc_i(32'h77, 0, 0, 13, 7'h13));
        put(32'h20, enc_j(16, 1));
        put(32'h24, enc_i(32'h77, 0, 0, 13, 7'h13));
        put(32'h28, enc_i(32'h77, 0, 0, 13, 7'h13));
        put(32'h2C, enc_i(32'h77, 0, 0, 13, 7'h13));
        put(32'h30, enc_i(1, 7, 0, 0, 7'h67));
        put(32'h40, enc_i(3, 0, 0, 15, 7'h13));
        put(32'h44, enc_j(2, 1));
        exp_fetch = '{32'h00, 32'h04, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h20, 32'h30, 32'h40, 32'h44};
        do_reset();
        run(24);
        chk("cf_fetch_count", ifetch.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < ifetch.size()) chk("cf_fetch_addr", ifetch[i], exp_fetch[i]);
        end
        chk("cf_retire_count", ret_cyc.size(), 9);
        chk("cf_halt_cycle", halt_cyc, 20);
        chk("cf_x13_skips", dut.rf_q[13], 32'd1);
        chk("cf_x14", dut.rf_q[14], 32'd2);
        chk("jal_link_kept", dut.rf_q[1], 32'h24);
        chk("cf_x15", dut.rf_q[15], 32'd3);
        chk("misaligned_tgt_pc", imem_addr, 32'h44);

        // Wait states on a load word
        clear_imem();
        put(32'h00, enc_i(32'h10C, 0, 2, 12, 7'h03));
        put(32'h04, ECALL);
        dmem[32'h43] <= 32'hCAFE_BABE;
        ilat = 3;
        dlat = 2;
        do_reset();
        run(12);
        ilat = 0;
        dlat = 0;
        chk("ws_retire_cycle", ret_at(0), 8);
        chk("ws_stable", unstable, 0);
        chk("ws_dreq_cycles", n_dreq, 3);
        if (acc_addr.size() > 0) begin
            chk("ws_addr", acc_addr[0], 32'h10C);
            chk("ws_be", 32'(acc_be[0]), 32'hF);
            chk("ws_we", 32'(acc_we[0]), 0);
        end
        chk("ws_x12", dut.rf_q[12], 32'hCAFE_BABE);

        // Misaligned load word faults before any data request
        clear_imem();
        put(32'h00, enc_i(32'h100, 0, 0, 5, 7'h13));
        put(32'h04, enc_i(2, 5, 2, 16, 7'h03));
        do_reset();
        run(10);
        chk("mis_retire_count", ret_cyc.size(), 1);
        chk("mis_no_dreq", n_dreq, 0);
        chk("mis_halt_cycle", halt_cyc, 4);
        chk("mis_pc", imem_addr, 32'h4);

        // RV32E instance: x20 not storage, then reset during a stalled load
        imem_e[0] = enc_i(9, 0, 0, 20, 7'h13);
        imem_e[1] = enc_r(7'h00, 0, 20, 0, 1, 7'h33);
        imem_e[2] = enc_i(7, 0, 0, 2, 7'h13);
        imem_e[3] = enc_i(32'h100, 0, 2, 3, 7'h03);
        repeat (2) @(posedge clk);
        #1;
        reset_n_e = 1'b1;
        chk("e_first_req", 32'(imem_req_e), 1);
        chk("e_first_addr", imem_addr_e, 32'h1000);
        rcount_e = 0;
        for (int c = 0; c < 10; c++) begin
            if (retired_e) rcount_e++;
            @(posedge clk);
            #1;
        end
        chk("e_retire_count", rcount_e, 3);
        chk("e_mem_wait", 32'(dmem_req_e), 1);
        chk("e_mem_addr", dmem_addr_e, 32'h100);
        reset_n_e = 1'b0;
        dack_en   = 1'b1;
        @(posedge clk);
        #1;
        chk("e_rst_dreq", 32'(dmem_req_e), 0);
        chk("e_rst_pc", imem_addr_e, 32'h1000);
        chk("e_late_ack_retire", 32'(retired_e), 0);
        chk("e_rst_halt", 32'(halt_e), 0);
        reset_n_e = 1'b1;
        dack_en   = 1'b0;
        chk("e_refetch_req", 32'(imem_req_e), 1);
        @(posedge clk);
        #1;
        chk("e_exec_no_req", 32'(imem_req_e), 0);
        chk("e_x1_rv32e", dut_e.rf_q[1], 32'h0);
        chk("e_x2", dut_e.rf_q[2], 32'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
